// File: rtl/mini_src_control_unit_if.sv
// Control-unit <-> datapath/top bundle: sequencing inputs plus every strobe, select and status line.
interface mini_src_control_unit_if #(
    parameter int unsigned OPW  = 5,
    parameter int unsigned NREG = 16
);
    logic            run;
    logic [31:0]     IR;
    logic            mem_ready;

    logic            PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
    logic            PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, IncPC, Read;
    logic [NREG-1:0] Rout;
    logic [NREG-1:0] Rin;
    logic [OPW-1:0]  opcode;
    logic            instr_done;
    logic            halted;
    logic            fault;

    modport master (
        input  run, IR, mem_ready,
        output PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
        output PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, IncPC, Read,
        output Rout, Rin, opcode, instr_done, halted, fault
    );

    modport slave (
        output run, IR, mem_ready,
        input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
        input  PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, IncPC, Read,
        input  Rout, Rin, opcode, instr_done, halted, fault
    );
endinterface

// File: rtl/mini_src_control_unit.sv
// Mini-SRC Moore control unit: fetch T0-T2, execute T3-T6 for register-only instructions.
// Strobes decode from the state register plus IR, so an async clear zeroes them in the same cycle.
module mini_src_control_unit #(
    parameter int unsigned OPW           = 5,
    parameter int unsigned NREG          = 16,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic                      clock,
    input  logic                      clear,
    mini_src_control_unit_if.master   ctrl
);
    localparam int unsigned CNTW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU3, C_UNARY, C_MULDIV, C_NOP, C_HALT, C_ILLEGAL
    } op_class_t;

    state_t          state, state_nx;
    logic [CNTW-1:0] cnt;
    logic            fault_q;
    op_class_t       cls;
    logic            timeout_hit;
    logic            illegal_now;

    logic [4:0]      op_field;
    logic [3:0]      ra, rb, rc;
    logic            unused_ir;

    assign op_field  = ctrl.IR[31:27];
    assign ra        = ctrl.IR[26:23];
    assign rb        = ctrl.IR[22:19];
    assign rc        = ctrl.IR[18:15];
    assign unused_ir = ^ctrl.IR[14:0];

    // Register index to one-hot select; indices beyond NREG select nothing.
    function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
        logic [NREG-1:0] v;
        for (int unsigned i = 0; i < NREG; i++) v[i] = (32'(idx) == i);
        return v;
    endfunction

    always_comb begin
        case (op_field)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: cls = C_ALU3;
            5'b10001, 5'b10010:                     cls = C_UNARY;
            5'b01111, 5'b10000:                     cls = C_MULDIV;
            5'b11010:                               cls = C_NOP;
            5'b11011:                               cls = C_HALT;
            default:                                cls = C_ILLEGAL;
        endcase
    end

    assign timeout_hit = (state == S_T1) && !ctrl.mem_ready && (cnt == CNTW'(FETCH_TIMEOUT - 1));
    assign illegal_now = (state == S_T3) && (cls == C_ILLEGAL);

    // State, fetch-wait counter and sticky fault.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= S_IDLE;
            cnt     <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= state_nx;
            if ((state == S_T1) && !ctrl.mem_ready && !timeout_hit) cnt <= cnt + CNTW'(1);
            else                                                    cnt <= '0;
            if (timeout_hit || illegal_now) fault_q <= 1'b1;
        end
    end

    always_comb begin
        state_t end_nx;
        end_nx   = ctrl.run ? S_T0 : S_IDLE;
        state_nx = state;
        case (state)
            S_IDLE: if (ctrl.run) state_nx = S_T0;
            S_T0:   state_nx = S_T1;
            S_T1: begin
                if (ctrl.mem_ready) state_nx = S_T2;
                else if (timeout_hit) state_nx = S_HALT;
            end
            S_T2:   state_nx = S_T3;
            S_T3: begin
                case (cls)
                    C_ALU3, C_UNARY, C_MULDIV: state_nx = S_T4;
                    C_HALT:                    state_nx = S_HALT;
                    default:                   state_nx = end_nx;
                endcase
            end
            S_T4:   state_nx = (cls == C_UNARY) ? end_nx : S_T5;
            S_T5:   state_nx = (cls == C_MULDIV) ? S_T6 : end_nx;
            S_T6:   state_nx = end_nx;
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl.PCout = 1'b0; ctrl.Zlowout = 1'b0; ctrl.Zhighout = 1'b0;
        ctrl.MDRout = 1'b0; ctrl.HIout = 1'b0; ctrl.LOout = 1'b0;
        ctrl.PCin = 1'b0; ctrl.MARin = 1'b0; ctrl.MDRin = 1'b0; ctrl.IRin = 1'b0;
        ctrl.Yin = 1'b0; ctrl.Zlowin = 1'b0; ctrl.Zhighin = 1'b0; ctrl.HIin = 1'b0;
        ctrl.LOin = 1'b0; ctrl.IncPC = 1'b0; ctrl.Read = 1'b0;
        ctrl.Rout = '0; ctrl.Rin = '0; ctrl.opcode = '0;
        ctrl.instr_done = 1'b0;
        ctrl.halted = (state == S_HALT);
        ctrl.fault  = fault_q | illegal_now;
        case (state)
            S_T0: begin
                ctrl.PCout = 1'b1; ctrl.MARin = 1'b1; ctrl.IncPC = 1'b1; ctrl.Zlowin = 1'b1;
            end
            // PC reload from Z repeats every wait cycle; harmless since Z is unchanged.
            S_T1: begin
                ctrl.Zlowout = 1'b1; ctrl.PCin = 1'b1; ctrl.Read = 1'b1; ctrl.MDRin = 1'b1;
            end
            S_T2: begin
                ctrl.MDRout = 1'b1; ctrl.IRin = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_ALU3:   begin ctrl.Rout = onehot(rb); ctrl.Yin = 1'b1; end
                    C_UNARY: begin
                        ctrl.Rout = onehot(rb); ctrl.opcode = OPW'(op_field); ctrl.Zlowin = 1'b1;
                    end
                    C_MULDIV: begin ctrl.Rout = onehot(ra); ctrl.Yin = 1'b1; end
                    C_NOP, C_ILLEGAL: ctrl.instr_done = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALU3: begin
                        ctrl.Rout = onehot(rc); ctrl.opcode = OPW'(op_field); ctrl.Zlowin = 1'b1;
                    end
                    C_UNARY: begin
                        ctrl.Zlowout = 1'b1; ctrl.Rin = onehot(ra); ctrl.instr_done = 1'b1;
                    end
                    C_MULDIV: begin
                        ctrl.Rout = onehot(rb); ctrl.opcode = OPW'(op_field);
                        ctrl.Zlowin = 1'b1; ctrl.Zhighin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                if (cls == C_MULDIV) begin
                    ctrl.Zlowout = 1'b1; ctrl.LOin = 1'b1;
                end else begin
                    ctrl.Zlowout = 1'b1; ctrl.Rin = onehot(ra); ctrl.instr_done = 1'b1;
                end
            end
            S_T6: begin
                ctrl.Zhighout = 1'b1; ctrl.HIin = 1'b1; ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mini_src_control_unit.sv
// Directed bench: per-cycle expected output vectors are queued by the stimulus and compared by a monitor.
module tb_mini_src_control_unit;
    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    mini_src_control_unit_if #(.OPW(5), .NREG(16)) bus ();

    mini_src_control_unit #(.OPW(5), .NREG(16), .FETCH_TIMEOUT(16)) dut (
        .clock (clock),
        .clear (clear),
        .ctrl  (bus)
    );

    // Strobe vector bit positions, drivers first then loads.
    localparam logic [16:0] PCOUT    = 17'b1 << 16;
    localparam logic [16:0] ZLOWOUT  = 17'b1 << 15;
    localparam logic [16:0] ZHIGHOUT = 17'b1 << 14;
    localparam logic [16:0] MDROUT   = 17'b1 << 13;
    localparam logic [16:0] PCIN     = 17'b1 << 10;
    localparam logic [16:0] MARIN    = 17'b1 << 9;
    localparam logic [16:0] MDRIN    = 17'b1 << 8;
    localparam logic [16:0] IRIN     = 17'b1 << 7;
    localparam logic [16:0] YIN      = 17'b1 << 6;
    localparam logic [16:0] ZLOWIN   = 17'b1 << 5;
    localparam logic [16:0] ZHIGHIN  = 17'b1 << 4;
    localparam logic [16:0] HIIN     = 17'b1 << 3;
    localparam logic [16:0] LOIN     = 17'b1 << 2;
    localparam logic [16:0] INCPC    = 17'b1 << 1;
    localparam logic [16:0] READ     = 17'b1;
    localparam logic [16:0] NONE     = 17'b0;

    logic [56:0] exp_q[$];
    string       name_q[$];
    logic        exp_halted, exp_fault;
    int          checks = 0;
    int          failures = 0;

    logic [56:0] act;
    assign act = {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.HIout, bus.LOout,
                  bus.PCin, bus.MARin, bus.MDRin, bus.IRin, bus.Yin, bus.Zlowin, bus.Zhighin,
                  bus.HIin, bus.LOin, bus.IncPC, bus.Read,
                  bus.Rout, bus.Rin, bus.opcode, bus.instr_done, bus.halted, bus.fault};

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            logic [56:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", n, act, e);
            end
        end
    end

    // Immediate comparison of a sampled value against its expectation.
    task automatic check(input string n, input logic [56:0] got, input logic [56:0] e);
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, got, e);
        end
    endtask

    task automatic push(input string n, input logic [16:0] s, input logic [15:0] ro,
                        input logic [15:0] ri, input logic [4:0] op, input logic d);
        exp_q.push_back({s, ro, ri, op, d, exp_halted, exp_fault});
        name_q.push_back(n);
    endtask

    task automatic step(input string n, input logic [16:0] s, input logic [15:0] ro,
                        input logic [15:0] ri, input logic [4:0] op, input logic d);
        @(posedge clock);
        #1;
        push(n, s, ro, ri, op, d);
    endtask

    // T0, T1 held for 'waits' extra cycles, T2; IR presented as the datapath would load it.
    task automatic do_fetch(input string n, input logic [31:0] ir, input int waits);
        step({n, "_t0"}, PCOUT | MARIN | INCPC | ZLOWIN, 16'h0, 16'h0, 5'b0, 1'b0);
        for (int i = 0; i <= waits; i++) begin
            step({n, "_t1"}, ZLOWOUT | PCIN | READ | MDRIN, 16'h0, 16'h0, 5'b0, 1'b0);
            bus.mem_ready = (i >= waits);
        end
        step({n, "_t2"}, MDROUT | IRIN, 16'h0, 16'h0, 5'b0, 1'b0);
        bus.mem_ready = 1'b0;
        bus.IR = ir;
    endtask

    initial begin
        clear = 1'b0;
        bus.run = 1'b0;
        bus.IR = 32'hFFFF_FFFF;
        bus.mem_ready = 1'b0;
        exp_halted = 1'b0;
        exp_fault = 1'b0;

        step("reset0", NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        step("reset1", NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        clear = 1'b1;
        step("idle0", NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        step("idle1", NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        bus.run = 1'b1;

        // neg R6,R7
        do_fetch("neg", 32'h8B380000, 0);
        step("neg_t3", ZLOWIN, 16'h0080, 16'h0, 5'b10001, 1'b0);
        step("neg_t4", ZLOWOUT, 16'h0, 16'h0040, 5'b0, 1'b1);

        // add R2,R3,R4 (Ra=2 Rb=3 Rc=4) with three wait cycles in T1
        do_fetch("add", 32'h191A0000, 3);
        step("add_t3", YIN, 16'h0008, 16'h0, 5'b0, 1'b0);
        step("add_t4", ZLOWIN, 16'h0010, 16'h0, 5'b00011, 1'b0);
        step("add_t5", ZLOWOUT, 16'h0, 16'h0004, 5'b0, 1'b1);

        // mul R5,R6; run dips mid-instruction and must be ignored until instr_done
        do_fetch("mul", 32'h7AB00000, 0);
        step("mul_t3", YIN, 16'h0020, 16'h0, 5'b0, 1'b0);
        bus.run = 1'b0;
        step("mul_t4", ZLOWIN | ZHIGHIN, 16'h0040, 16'h0, 5'b01111, 1'b0);
        bus.run = 1'b1;
        step("mul_t5", ZLOWOUT | LOIN, 16'h0, 16'h0, 5'b0, 1'b0);
        step("mul_t6", ZHIGHOUT | HIIN, 16'h0, 16'h0, 5'b0, 1'b1);
        bus.run = 1'b0;
        step("mul_idle", NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        bus.run = 1'b1;

        // add again, cleared asynchronously in the middle of T4
        do_fetch("add2", 32'h191A0000, 0);
        step("add2_t3", YIN, 16'h0008, 16'h0, 5'b0, 1'b0);
        @(posedge clock);
        #1;
        clear = 1'b0;
        #1;
        check("rst_now", act, 57'b0);
        push("rst_mid_t4", NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        step("rst_hold", NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        clear = 1'b1;

        // mem_ready never arrives: 16 T1 cycles, then fault and HALT
        step("to_t0", PCOUT | MARIN | INCPC | ZLOWIN, 16'h0, 16'h0, 5'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            step("to_t1", ZLOWOUT | PCIN | READ | MDRIN, 16'h0, 16'h0, 5'b0, 1'b0);
        exp_fault = 1'b1;
        exp_halted = 1'b1;
        step("to_halt0", NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        check("to_expired", {55'b0, bus.halted, bus.fault}, 57'b11);
        step("to_halt1", NONE, 16'h0, 16'h0, 5'b0, 1'b0);

        @(posedge clock);
        #1;
        clear = 1'b0;
        exp_fault = 1'b0;
        exp_halted = 1'b0;
        #1;
        push("rst_halt", NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        step("rst_rel", NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        clear = 1'b1;

        // illegal op 11111: fault at T3, fetching continues
        do_fetch("ill", 32'hF8000000, 0);
        exp_fault = 1'b1;
        step("ill_t3", NONE, 16'h0, 16'h0, 5'b0, 1'b1);
        do_fetch("nop", 32'hD0000000, 0);
        step("nop_t3", NONE, 16'h0, 16'h0, 5'b0, 1'b1);

        // halt op, then run toggling has no effect
        do_fetch("hlt", 32'hD8000000, 0);
        step("hlt_t3", NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        exp_halted = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("halted", NONE, 16'h0, 16'h0, 5'b0, 1'b0);
            bus.run = ~bus.run;
        end

        @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
